// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types for the ROM fetch arbiter: requester id encoding and the default word width.
package rom_fetch_arbiter_pkg;

  localparam int unsigned PORT_WORD_WIDTH = 32;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Bundle of the IFU, LSU and ROM request/response channels around the arbiter.
// master = arbiter view, slave = environment view (requesters and ROM).
interface rom_fetch_arbiter_if #(
  parameter int unsigned ADDR_W = rom_fetch_arbiter_pkg::PORT_WORD_WIDTH,
  parameter int unsigned DATA_W = rom_fetch_arbiter_pkg::PORT_WORD_WIDTH
) ();

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_ready;
  logic [DATA_W-1:0] ifu_rsp_data;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_ready;
  logic [DATA_W-1:0] lsu_rsp_data;

  logic              rom_req_valid;
  logic              rom_req_ready;
  logic [ADDR_W-1:0] rom_req_addr;
  logic              rom_rsp_valid;
  logic [DATA_W-1:0] rom_rsp_data;

  modport master (
    input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_rsp_ready,
    input  rom_req_ready, rom_rsp_valid, rom_rsp_data,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output rom_req_valid, rom_req_addr
  );

  modport slave (
    output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_rsp_ready,
    output rom_req_ready, rom_rsp_valid, rom_rsp_data,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  rom_req_valid, rom_req_addr
  );

endinterface

// File: rtl/rom_fetch_arbiter_rsp_queue.sv
// rom_rsp_queue: allocate-on-issue ring of {id, filled, data}; ROM returns fill the
// oldest unfilled entry, the head is popped once filled and consumed.
module rom_rsp_queue
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = PORT_WORD_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  req_id_e           alloc_id,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pop,
  output logic              head_valid,
  output req_id_e           head_id,
  output logic [DATA_W-1:0] head_data,
  output logic              full
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0]  filled_q, filled_d;
  req_id_e           id_q   [DEPTH];
  req_id_e           id_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, fill_ptr_q, fill_ptr_d;
  logic [CNT_W-1:0]  alloc_cnt_q, alloc_cnt_d, in_flight_q, in_flight_d;
  logic              fill_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    filled_d    = filled_q;
    id_d        = id_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_ptr_d  = fill_ptr_q;
    // Returns with nothing outstanding belong to pre-reset requests.
    fill_en     = fill_valid && (in_flight_q != '0);

    // Pop before alloc: when full, a same-cycle alloc reuses the popped head slot.
    if (pop) begin
      filled_d[head_q] = 1'b0;
      head_d           = ptr_inc(head_q);
    end
    if (alloc_valid) begin
      filled_d[tail_q] = 1'b0;
      id_d[tail_q]     = alloc_id;
      tail_d           = ptr_inc(tail_q);
    end
    if (fill_en) begin
      filled_d[fill_ptr_q] = 1'b1;
      data_d[fill_ptr_q]   = fill_data;
      fill_ptr_d           = ptr_inc(fill_ptr_q);
    end

    alloc_cnt_d = alloc_cnt_q + CNT_W'(alloc_valid) - CNT_W'(pop);
    in_flight_d = in_flight_q + CNT_W'(alloc_valid) - CNT_W'(fill_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filled_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      fill_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      in_flight_q <= '0;
    end else begin
      filled_q    <= filled_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_ptr_q  <= fill_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      in_flight_q <= in_flight_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q   <= id_d;
    data_q <= data_d;
  end

  assign head_valid = filled_q[head_q];
  assign head_id    = id_q[head_q];
  assign head_data  = data_q[head_q];
  assign full       = (alloc_cnt_q == CNT_MAX);

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing the instruction ROM between IFU and LSU, with in-order response routing.
// Optional macro ROM_ARB_PERF_EN adds per-requester 32-bit grant counters.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = PORT_WORD_WIDTH,
  parameter int unsigned DATA_W = PORT_WORD_WIDTH,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  rom_fetch_arbiter_if.master bus
`ifdef ROM_ARB_PERF_EN
  ,
  output logic [31:0]         ifu_grant_cnt,
  output logic [31:0]         lsu_grant_cnt
`endif
);

  req_id_e           last_grant_q, last_grant_d, sel_id, head_id;
  logic              head_valid, full, pop, allowed, accept;
  logic              ifu_rsp_v, lsu_rsp_v;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    ifu_rsp_v = !rst && head_valid && (head_id == REQ_IFU);
    lsu_rsp_v = !rst && head_valid && (head_id == REQ_LSU);
    pop       = (ifu_rsp_v && bus.ifu_rsp_ready) || (lsu_rsp_v && bus.lsu_rsp_ready);

    if (bus.ifu_req_valid && bus.lsu_req_valid)
      sel_id = (last_grant_q == REQ_IFU) ? REQ_LSU : REQ_IFU;
    else
      sel_id = bus.lsu_req_valid ? REQ_LSU : REQ_IFU;

    // A same-cycle pop frees a slot, so a full queue still issues while draining.
    allowed = !rst && (!full || pop);

    bus.rom_req_valid = allowed && (bus.ifu_req_valid || bus.lsu_req_valid);
    bus.rom_req_addr  = '0;
    if (bus.rom_req_valid)
      bus.rom_req_addr = (sel_id == REQ_LSU) ? bus.lsu_req_addr : bus.ifu_req_addr;

    accept            = bus.rom_req_valid && bus.rom_req_ready;
    bus.ifu_req_ready = accept && (sel_id == REQ_IFU);
    bus.lsu_req_ready = accept && (sel_id == REQ_LSU);
    last_grant_d      = accept ? sel_id : last_grant_q;

    bus.ifu_rsp_valid = ifu_rsp_v;
    bus.lsu_rsp_valid = lsu_rsp_v;
    bus.ifu_rsp_data  = ifu_rsp_v ? head_data : '0;
    bus.lsu_rsp_data  = lsu_rsp_v ? head_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= REQ_LSU;
    else     last_grant_q <= last_grant_d;
  end

  rom_rsp_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_rsp_queue (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (accept),
    .alloc_id    (sel_id),
    .fill_valid  (bus.rom_rsp_valid),
    .fill_data   (bus.rom_rsp_data),
    .pop         (pop),
    .head_valid  (head_valid),
    .head_id     (head_id),
    .head_data   (head_data),
    .full        (full)
  );

`ifdef ROM_ARB_PERF_EN
  logic [31:0] ifu_grant_cnt_q, ifu_grant_cnt_d, lsu_grant_cnt_q, lsu_grant_cnt_d;

  always_comb begin
    ifu_grant_cnt_d = ifu_grant_cnt_q + 32'(bus.ifu_req_ready);
    lsu_grant_cnt_d = lsu_grant_cnt_q + 32'(bus.lsu_req_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifu_grant_cnt_q <= '0;
      lsu_grant_cnt_q <= '0;
    end else begin
      ifu_grant_cnt_q <= ifu_grant_cnt_d;
      lsu_grant_cnt_q <= lsu_grant_cnt_d;
    end
  end

  assign ifu_grant_cnt = ifu_grant_cnt_q;
  assign lsu_grant_cnt = lsu_grant_cnt_q;
`endif

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Scoreboard bench for rom_fetch_arbiter: a behavioural ROM with configurable latency,
// expected responses queued on each accept and compared in order on delivery.
module tb_rom_fetch_arbiter;
  import rom_fetch_arbiter_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rom_fetch_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ROM_ARB_PERF_EN
  logic [31:0] ifu_grant_cnt, lsu_grant_cnt;
`endif

  rom_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ROM_ARB_PERF_EN
    ,
    .ifu_grant_cnt (ifu_grant_cnt),
    .lsu_grant_cnt (lsu_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct packed {
    int unsigned   due;
    logic [DW-1:0] data;
  } rom_t;

  exp_t        exp_q[$];
  rom_t        rom_q[$];
  logic        grant_log[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;
  int unsigned rom_lat  = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'h5A00_0000 + ((a >> 2) * 32'd17);
  endfunction

  // Behavioural ROM: fixed latency, in order, cannot be stalled
  initial begin
    rom_t r;
    bus.rom_rsp_valid = 1'b0;
    bus.rom_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rom_q.size() != 0 && cyc >= rom_q[0].due) begin
        r = rom_q.pop_front();
        bus.rom_rsp_valid = 1'b1;
        bus.rom_rsp_data  = r.data;
      end else begin
        bus.rom_rsp_valid = 1'b0;
        bus.rom_rsp_data  = '0;
      end
    end
  end

  logic          ih, lh, hold_ifu, hold_lsu;
  logic [DW-1:0] hold_ifu_data, hold_lsu_data;
  exp_t          e;
  rom_t          rn;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_outputs",
            64'({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
                 bus.rom_req_valid, (bus.ifu_rsp_data | bus.lsu_rsp_data | bus.rom_req_addr) != '0}),
            64'(0));
      hold_ifu = 1'b0;
      hold_lsu = 1'b0;
    end else begin
      ih = bus.ifu_req_valid & bus.ifu_req_ready;
      lh = bus.lsu_req_valid & bus.lsu_req_ready;
      if (bus.rom_req_valid && bus.rom_req_ready) begin
        check("rom_hs_has_grant", 64'(ih | lh), 64'(1));
        rn.due  = cyc + rom_lat;
        rn.data = rom_word(bus.rom_req_addr);
        rom_q.push_back(rn);
      end
      if (ih | lh) begin
        check("single_grant", 64'(ih & lh), 64'(0));
        check("rom_req_addr", 64'(bus.rom_req_addr), 64'(ih ? bus.ifu_req_addr : bus.lsu_req_addr));
        e.id   = lh;
        e.data = rom_word(ih ? bus.ifu_req_addr : bus.lsu_req_addr);
        exp_q.push_back(e);
        grant_log.push_back(lh);
      end
      if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) begin
        check("dual_rsp", 64'(bus.ifu_rsp_valid & bus.lsu_rsp_valid), 64'(0));
        if (exp_q.size() == 0)
          check("spurious_rsp", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'(0));
      end
      if (hold_ifu) check("ifu_hold", 64'({bus.ifu_rsp_valid, bus.ifu_rsp_data}), 64'({1'b1, hold_ifu_data}));
      if (hold_lsu) check("lsu_hold", 64'({bus.lsu_rsp_valid, bus.lsu_rsp_data}), 64'({1'b1, hold_lsu_data}));
      if (bus.ifu_rsp_valid && bus.ifu_rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ifu_rsp_route", 64'(e.id), 64'(REQ_IFU));
        check("ifu_rsp_data", 64'(bus.ifu_rsp_data), 64'(e.data));
      end
      if (bus.lsu_rsp_valid && bus.lsu_rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("lsu_rsp_route", 64'(e.id), 64'(REQ_LSU));
        check("lsu_rsp_data", 64'(bus.lsu_rsp_data), 64'(e.data));
      end
      hold_ifu      = bus.ifu_rsp_valid & ~bus.ifu_rsp_ready;
      hold_lsu      = bus.lsu_rsp_valid & ~bus.lsu_rsp_ready;
      hold_ifu_data = bus.ifu_rsp_data;
      hold_lsu_data = bus.lsu_rsp_data;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    grant_log.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue(input logic id, input logic [AW-1:0] a);
    logic ok;
    ok = 1'b0;
    if (id == REQ_IFU) begin bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = a; end
    else               begin bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = a; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id == REQ_IFU) ? bus.ifu_req_ready : bus.lsu_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("issue_accept", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    if (id == REQ_IFU) bus.ifu_req_valid = 1'b0;
    else               bus.lsu_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h20;
    bus.lsu_req_addr  = 32'h40;
    bus.ifu_rsp_ready = 1'b1;
    bus.lsu_rsp_ready = 1'b1;
    bus.rom_req_ready = 1'b1;

    // Both requesters valid from reset: strict alternation starting with IFU
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    drain();
    check("grant_log_len", 64'(grant_log.size() >= 4), 64'(1));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("grant_order_%0d", i), 64'(grant_log[i]), 64'(i % 2));

    // IFU only, back-to-back sequential fetches
    issue(REQ_IFU, 32'h0);
    issue(REQ_IFU, 32'h4);
    issue(REQ_IFU, 32'h8);
    drain();

    // Queue full blocks both requesters; issue resumes on the popping cycle
    bus.ifu_rsp_ready = 1'b0;
    issue(REQ_IFU, 32'h30);
    issue(REQ_IFU, 32'h34);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h38;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h50;
    repeat (3) begin
      @(negedge clk);
      check("full_ifu_ready", 64'(bus.ifu_req_ready), 64'(0));
      check("full_lsu_ready", 64'(bus.lsu_req_ready), 64'(0));
      check("full_rom_valid", 64'(bus.rom_req_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    bus.ifu_rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_ifu_rsp_valid", 64'(bus.ifu_rsp_valid), 64'(1));
    check("resume_lsu_ready", 64'(bus.lsu_req_ready), 64'(1));
    check("resume_ifu_ready", 64'(bus.ifu_req_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b0;
    issue(REQ_IFU, 32'h38);
    drain();

    // ROM back-pressure holds the request address without allocating
    bus.rom_req_ready = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h10;
    repeat (3) begin
      @(negedge clk);
      check("stall_rom_valid", 64'(bus.rom_req_valid), 64'(1));
      check("stall_rom_addr", 64'(bus.rom_req_addr), 64'(32'h10));
      check("stall_ifu_ready", 64'(bus.ifu_req_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    bus.rom_req_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", 64'(bus.ifu_req_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    drain();

    // Reset with two requests in flight: late ROM returns must be dropped
    rom_lat = 3;
    issue(REQ_IFU, 32'h60);
    issue(REQ_IFU, 32'h64);
    do_reset();
    rom_lat = 1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_ifu_rsp", 64'(bus.ifu_rsp_valid), 64'(0));
      check("post_rst_lsu_rsp", 64'(bus.lsu_rsp_valid), 64'(0));
    end
    issue(REQ_LSU, 32'h70);
    drain();

`ifdef ROM_ARB_PERF_EN
    do_reset();
    repeat (5) issue(REQ_IFU, 32'h100);
    repeat (3) issue(REQ_LSU, 32'h200);
    drain();
    @(negedge clk);
    check("ifu_grant_cnt", 64'(ifu_grant_cnt), 64'(5));
    check("lsu_grant_cnt", 64'(lsu_grant_cnt), 64'(3));
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("ifu_grant_cnt_rst", 64'(ifu_grant_cnt), 64'(0));
    check("lsu_grant_cnt_rst", 64'(lsu_grant_cnt), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
